// File: rtl/lc3_int_ctrl_if.sv
// Bus between the LC-3 pipeline FSM / MMIO decoder and the external interrupt controller.
interface lc3_int_ctrl_if #(
  parameter int unsigned NSRC = 4
);
  logic [NSRC-1:0] irq;
  logic [2:0]      psr_pri;
  logic            int_ack;
  logic            int_done;
  logic            reg_wr;
  logic [1:0]      reg_addr;
  logic [15:0]     reg_wdata;
  logic [15:0]     reg_rdata;
  logic            INT;
  logic [15:0]     ExtINTvec;
  logic            in_service;

  modport master (
    output irq, psr_pri, int_ack, int_done, reg_wr, reg_addr, reg_wdata,
    input  reg_rdata, INT, ExtINTvec, in_service
  );

  modport slave (
    input  irq, psr_pri, int_ack, int_done, reg_wr, reg_addr, reg_wdata,
    output reg_rdata, INT, ExtINTvec, in_service
  );
endinterface

// File: rtl/lc3_int_ctrl.sv
// External interrupt controller: IRQ sync/edge latch, priority arbitration against PSR,
// single in-service tracking, MMIO register file (IMR/IPR/PRIO/ISR). State moves on negedge.
module lc3_int_ctrl #(
  parameter int unsigned NSRC     = 4,
  parameter logic [15:0] VEC_BASE = 16'h0180
) (
  input logic            clk,
  input logic            reset,
  lc3_int_ctrl_if.slave  bus
);
  localparam int unsigned WW = (NSRC > 1) ? $clog2(NSRC) : 1;

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t            state, state_n;
  logic [NSRC-1:0]   s1, s2, s3, irq_rise;
  logic [NSRC-1:0]   imr, imr_n, ipr, ipr_n, isr, isr_n, cand;
  logic [3*NSRC-1:0] prio, prio_n;
  logic [WW-1:0]     cur, cur_n, best_idx;
  logic [2:0]        best_pri, cur_pri;
  logic [15:0]       vec, vec_n;
  logic              unused_wdata;

  assign unused_wdata = ^bus.reg_wdata;
  assign irq_rise     = s2 & ~s3;
  assign cand         = ipr & imr;
  assign cur_pri      = prio[3*cur +: 3];

  // Strict '>' keeps the lowest index on ties and never lets a PRIO=0 source win.
  always_comb begin
    best_pri = '0;
    best_idx = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (cand[i] && (prio[3*i +: 3] > best_pri)) begin
        best_pri = prio[3*i +: 3];
        best_idx = WW'(i);
      end
    end
  end

  always_comb begin
    imr_n  = imr;
    ipr_n  = ipr;
    prio_n = prio;
    if (bus.reg_wr) begin
      case (bus.reg_addr)
        2'd0:    imr_n  = bus.reg_wdata[NSRC-1:0];
        2'd1:    ipr_n  = ipr & ~bus.reg_wdata[NSRC-1:0];
        2'd2:    prio_n = bus.reg_wdata[3*NSRC-1:0];
        default: ;
      endcase
    end
    if ((state == REQ) && bus.int_ack)
      ipr_n[cur] = 1'b0;
    ipr_n = ipr_n | irq_rise;
  end

  // Cancellation looks at post-write register values so INT drops on the same edge
  // that applies the clearing write; a simultaneous new edge keeps the request alive.
  always_comb begin
    state_n = state;
    cur_n   = cur;
    vec_n   = vec;
    isr_n   = isr;
    case (state)
      IDLE: begin
        if (best_pri > bus.psr_pri) begin
          state_n = REQ;
          cur_n   = best_idx;
          vec_n   = VEC_BASE + 16'(best_idx);
        end
      end
      REQ: begin
        if (bus.int_ack) begin
          state_n    = SERVICE;
          isr_n      = '0;
          isr_n[cur] = 1'b1;
        end else if (!ipr_n[cur] || !imr_n[cur] || (prio_n[3*cur +: 3] <= bus.psr_pri)) begin
          state_n = IDLE;
        end else if ((best_pri > cur_pri) && (best_pri > bus.psr_pri)) begin
          cur_n = best_idx;
          vec_n = VEC_BASE + 16'(best_idx);
        end
      end
      SERVICE: begin
        if (bus.int_done) begin
          state_n = IDLE;
          isr_n   = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      s1    <= '0;
      s2    <= '0;
      s3    <= '0;
      imr   <= '0;
      ipr   <= '0;
      prio  <= '0;
      isr   <= '0;
      cur   <= '0;
      vec   <= VEC_BASE;
    end else begin
      state <= state_n;
      s1    <= bus.irq;
      s2    <= s1;
      s3    <= s2;
      imr   <= imr_n;
      ipr   <= ipr_n;
      prio  <= prio_n;
      isr   <= isr_n;
      cur   <= cur_n;
      vec   <= vec_n;
    end
  end

  assign bus.INT        = (state == REQ);
  assign bus.in_service = (state == SERVICE);
  assign bus.ExtINTvec  = vec;

  always_comb begin
    bus.reg_rdata = '0;
    case (bus.reg_addr)
      2'd0:    bus.reg_rdata[NSRC-1:0]   = imr;
      2'd1:    bus.reg_rdata[NSRC-1:0]   = ipr;
      2'd2:    bus.reg_rdata[3*NSRC-1:0] = prio;
      default: bus.reg_rdata[NSRC-1:0]   = isr;
    endcase
  end
endmodule

// File: tb/tb_lc3_int_ctrl.sv
// Directed + randomized bench for lc3_int_ctrl against a per-cycle behavioural model.
module tb_lc3_int_ctrl;
  localparam int unsigned NSRC     = 4;
  localparam logic [15:0] VEC_BASE = 16'h0180;

  logic clk = 1'b1;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  lc3_int_ctrl_if #(.NSRC(NSRC)) bus ();

  lc3_int_ctrl #(.NSRC(NSRC), .VEC_BASE(VEC_BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Model: pending/mask as bit sets, priorities as ints, phase 0=idle 1=requesting 2=servicing.
  bit [NSRC-1:0] m_imr, m_ipr, m_isr;
  int            m_prio [NSRC];
  int            m_phase, m_w;
  logic [15:0]   m_vec;
  bit [NSRC-1:0] hist [3];

  function automatic void model_reset();
    m_imr = '0; m_ipr = '0; m_isr = '0;
    foreach (m_prio[i]) m_prio[i] = 0;
    m_phase = 0; m_w = 0; m_vec = VEC_BASE;
    foreach (hist[k]) hist[k] = '0;
  endfunction

  function automatic void model_step();
    int best = -1;
    int bp = 0;
    int psr = int'(bus.psr_pri);
    bit [NSRC-1:0] n_imr = m_imr;
    bit [NSRC-1:0] n_ipr = m_ipr;
    int n_prio [NSRC];
    foreach (m_prio[i]) n_prio[i] = m_prio[i];
    for (int i = 0; i < NSRC; i++)
      if (m_ipr[i] && m_imr[i] && m_prio[i] > bp) begin bp = m_prio[i]; best = i; end
    if (bus.reg_wr) begin
      if (bus.reg_addr == 2'd0) n_imr = bus.reg_wdata[NSRC-1:0];
      if (bus.reg_addr == 2'd1) n_ipr = m_ipr & ~bus.reg_wdata[NSRC-1:0];
      if (bus.reg_addr == 2'd2)
        for (int i = 0; i < NSRC; i++) n_prio[i] = int'((bus.reg_wdata >> (3*i)) & 16'h7);
    end
    if (m_phase == 1 && bus.int_ack) n_ipr[m_w] = 1'b0;
    for (int i = 0; i < NSRC; i++) if (hist[1][i] && !hist[2][i]) n_ipr[i] = 1'b1;
    case (m_phase)
      0: if (best >= 0 && bp > psr) begin
           m_phase = 1; m_w = best; m_vec = 16'(VEC_BASE + best);
         end
      1: if (bus.int_ack) begin
           m_phase = 2; m_isr = '0; m_isr[m_w] = 1'b1;
         end else if (!n_ipr[m_w] || !n_imr[m_w] || n_prio[m_w] <= psr) begin
           m_phase = 0;
         end else if (best >= 0 && bp > m_prio[m_w] && bp > psr) begin
           m_w = best; m_vec = 16'(VEC_BASE + best);
         end
      default: if (bus.int_done) begin m_phase = 0; m_isr = '0; end
    endcase
    m_imr = n_imr; m_ipr = n_ipr;
    foreach (m_prio[i]) m_prio[i] = n_prio[i];
    hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = bus.irq;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [1:0] a, output logic [15:0] d);
    bus.reg_addr = a;
    #1 d = bus.reg_rdata;
  endtask

  task automatic check_all();
    logic [15:0] d, pr;
    pr = '0;
    for (int i = 0; i < NSRC; i++) pr = pr | 16'(m_prio[i] << (3*i));
    chk("INT", {15'b0, bus.INT}, {15'b0, m_phase == 1});
    chk("vec", bus.ExtINTvec, m_vec);
    chk("in_service", {15'b0, bus.in_service}, {15'b0, m_phase == 2});
    rd(2'd0, d); chk("IMR", d, 16'(m_imr));
    rd(2'd1, d); chk("IPR", d, 16'(m_ipr));
    rd(2'd2, d); chk("PRIO", d, pr);
    rd(2'd3, d); chk("ISR", d, 16'(m_isr));
  endtask

  // One negedge: model follows the inputs that were driven, then outputs/registers are checked
  // and single-cycle strobes drop.
  task automatic cycle();
    @(negedge clk);
    if (!reset) model_step();
    #1 check_all();
    bus.reg_wr = 1'b0; bus.int_ack = 1'b0; bus.int_done = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    bus.reg_wr = 1'b1; bus.reg_addr = a; bus.reg_wdata = d;
    cycle();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    logic [15:0] d;
    bus.irq = '0; bus.psr_pri = '0; bus.int_ack = 1'b0; bus.int_done = 1'b0;
    bus.reg_wr = 1'b0; bus.reg_addr = '0; bus.reg_wdata = '0;
    model_reset();
    #12 reset = 1'b0;
    #1 check_all();

    // Single source request, ack, done.
    wr(2'd0, 16'h0002);
    wr(2'd2, 16'h0018);
    bus.irq = 4'b0010;
    cycles(3);
    rd(2'd1, d); chk("t1_ipr", d, 16'h0002);
    cycle();
    chk("t1_int", {15'b0, bus.INT}, 16'h0001);
    chk("t1_vec", bus.ExtINTvec, 16'h0181);
    bus.int_ack = 1'b1; cycle();
    chk("t2_int", {15'b0, bus.INT}, 16'h0000);
    rd(2'd3, d); chk("t2_isr", d, 16'h0002);
    rd(2'd1, d); chk("t2_ipr", d, 16'h0000);
    chk("t2_insvc", {15'b0, bus.in_service}, 16'h0001);
    bus.int_done = 1'b1; cycle();
    chk("t2_done", {15'b0, bus.in_service}, 16'h0000);

    // Two sources pending together: higher priority first, other stays pending.
    bus.irq = '0; cycle();
    wr(2'd0, 16'h0005);
    wr(2'd2, 16'h0142);
    bus.irq = 4'b0101;
    cycles(4);
    chk("t3_vec", bus.ExtINTvec, 16'h0182);
    bus.int_ack = 1'b1; cycle();
    rd(2'd1, d); chk("t3_ipr", d, 16'h0001);
    bus.int_done = 1'b1; cycle();
    cycle();
    chk("t3_int2", {15'b0, bus.INT}, 16'h0001);
    chk("t3_vec2", bus.ExtINTvec, 16'h0180);
    bus.int_ack = 1'b1; cycle();
    bus.int_done = 1'b1; cycle();
    bus.irq = '0; cycles(2);

    // PSR priority blocks until it drops below the source priority.
    bus.psr_pri = 3'd4;
    wr(2'd0, 16'h0002);
    wr(2'd2, 16'h0020);
    bus.irq = 4'b0010;
    cycles(5);
    chk("t4_block", {15'b0, bus.INT}, 16'h0000);
    bus.psr_pri = 3'd3; cycle();
    chk("t4_int", {15'b0, bus.INT}, 16'h0001);
    chk("t4_vec", bus.ExtINTvec, 16'h0181);

    // W1C of the requesting source cancels; W1C racing a new edge loses.
    wr(2'd1, 16'h0002);
    chk("t5_cancel", {15'b0, bus.INT}, 16'h0000);
    bus.irq = '0; cycles(3);
    bus.irq = 4'b0010; cycles(2);
    wr(2'd1, 16'h0002);
    rd(2'd1, d); chk("t5_race", d, 16'h0002);
    cycle();
    chk("t6_int", {15'b0, bus.INT}, 16'h0001);

    // Asynchronous reset in the middle of a request.
    #1 reset = 1'b1;
    model_reset();
    #1 check_all();
    chk("t6_vec", bus.ExtINTvec, 16'h0180);
    @(negedge clk);
    #1 reset = 1'b0;
    bus.irq = '0; bus.psr_pri = '0;

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(3) == 0) bus.irq = bus.irq ^ NSRC'($urandom);
      if ($urandom_range(7) == 0) bus.psr_pri = 3'($urandom);
      if ($urandom_range(3) == 0) begin
        bus.reg_wr = 1'b1;
        bus.reg_addr = 2'($urandom);
        bus.reg_wdata = 16'($urandom);
      end
      bus.int_ack  = ($urandom_range(3) == 0);
      bus.int_done = ($urandom_range(4) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
